// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide sequencer:
// funct3 opcodes, FSM state encoding and datapath mode.
package muldiv_pkg;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_t;

    function automatic logic op_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shared radix-2 datapath: shift-add multiply and restoring divide on
// unsigned magnitudes, one step per cycle while step is high.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  mode_t           mode,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic [XLEN-1:0] prod_hi,
    output logic [XLEN-1:0] prod_lo,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem
);

    // acc: product high half / partial remainder; sh: multiplier / dividend,
    // which fills with product low bits or quotient bits as it shifts.
    logic [XLEN:0]   acc;
    logic [XLEN-1:0] md;
    logic [XLEN-1:0] sh;

    logic [XLEN:0] add_sum;
    logic [XLEN:0] trial;
    logic [XLEN:0] diff;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        add_sum = acc + (sh[0] ? {1'b0, md} : '0);
        trial   = {acc[XLEN-1:0], sh[XLEN-1]};
        diff    = trial - {1'b0, md};
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            md  <= '0;
            sh  <= '0;
        end else if (load) begin
            acc <= '0;
            md  <= b_mag;
            sh  <= a_mag;
        end else if (step) begin
            if (mode == MODE_MUL) begin
                acc <= {1'b0, add_sum[XLEN:1]};
                sh  <= {add_sum[0], sh[XLEN-1:1]};
            end else if (trial >= {1'b0, md}) begin
                acc <= diff;
                sh  <= {sh[XLEN-2:0], 1'b1};
            end else begin
                acc <= trial;
                sh  <= {sh[XLEN-2:0], 1'b0};
            end
        end
    end

    assign prod_hi = acc[XLEN-1:0];
    assign prod_lo = sh;
    assign quot    = sh;
    assign rem     = acc[XLEN-1:0];

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer for the EX stage: FSM, iteration counter,
// sign handling, divide corner cases and the stall/result handshake.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            flush,
    output logic            stall,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op;
    logic [XLEN-1:0]  a_reg;
    logic [XLEN-1:0]  b_reg;
    logic             neg_res;
    logic             neg_rem;

    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] fast_res, fix_res;
    logic [XLEN-1:0] prod_hi, prod_lo, quot, rem;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] quot_fix, rem_fix;

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .clk     (clk),
        .rst     (rst),
        .load    (state == S_PREP),
        .step    (state == S_CALC),
        .mode    (op_is_div(op) ? MODE_DIV : MODE_MUL),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .prod_hi (prod_hi),
        .prod_lo (prod_lo),
        .quot    (quot),
        .rem     (rem)
    );

    always_comb begin
        a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg    = a_signed & a_reg[XLEN-1];
        b_neg    = b_signed & b_reg[XLEN-1];
        a_mag    = a_neg ? -a_reg : a_reg;
        b_mag    = b_neg ? -b_reg : b_reg;

        div_zero = op_is_div(op) && (b_reg == '0);
        div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (a_reg == MIN_NEG) && (b_reg == '1);

        // Divide by zero: quotient all ones, remainder = dividend.
        // Signed overflow: quotient = dividend (MIN_NEG), remainder = 0.
        if (div_zero)
            fast_res = op[1] ? a_reg : '1;
        else
            fast_res = op[1] ? '0 : MIN_NEG;

        prod     = {prod_hi, prod_lo};
        if (neg_res)
            prod = -prod;
        quot_fix = neg_res ? -quot : quot;
        rem_fix  = neg_rem ? -rem : rem;

        case (op)
            OP_MUL:                        fix_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_res = quot_fix;
            default:                       fix_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            op           <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            neg_res      <= 1'b0;
            neg_rem      <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
        end else if (flush) begin
            state        <= S_IDLE;
            cnt          <= '0;
            result_valid <= 1'b0;
            result       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    result_valid <= 1'b0;
                    result       <= '0;
                    if (req_valid) begin
                        op    <= funct3;
                        a_reg <= rs1_val;
                        b_reg <= rs2_val;
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    neg_res <= a_neg ^ b_neg;
                    neg_rem <= a_neg;
                    cnt     <= CNT_W'(XLEN);
                    if (div_zero || div_ovf) begin
                        result       <= fast_res;
                        result_valid <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= S_FIX;
                end
                S_FIX: begin
                    result       <= fix_res;
                    result_valid <= 1'b1;
                    state        <= S_DONE;
                end
                S_DONE: begin
                    result_valid <= 1'b0;
                    result       <= '0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Combinational so flush/rst release the pipeline in the same cycle.
    assign stall = !rst && !flush &&
                   (((state == S_IDLE) && req_valid) || (state == S_PREP) ||
                    (state == S_CALC) || (state == S_FIX));
    assign busy  = (state != S_IDLE);

endmodule
